sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's FIFO blocks: arbitrary (non-power-of-two) depth, registered occupancy count, programmable almost-full/almost-empty thresholds, and a compile-time first-word-fall-through (FWFT) read mode. It buffers data between two producer/consumer stages that share one clock domain. Full/empty detection uses a wrap toggle bit per pointer, so all DEPTH entries are usable.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_mem.sv | 50 +++++
 rtl/sync_fifo_param.sv | 151 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer-width arithmetic and
// parameter-legality checks evaluated at elaboration time.
package fifo_pkg;

    // Number of bits needed to address `value` distinct entries (minimum 0).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Pointer width must exactly address DEPTH entries.
    function automatic bit ptr_width_legal(input int depth, input int ptr_width);
        return (depth >= 2) && (ptr_width == clog2(depth));
    endfunction

    // Thresholds must lie in range and leave a gap between almost-empty
    // and almost-full so the two flags never assert together.
    function automatic bit levels_legal(input int depth, input int af_level, input int ae_level);
        return (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1) &&
               (ae_level < af_level);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: one synchronous write port and one
// read port. The read port is combinational when FIFO_FWFT_EN is defined
// (first-word-fall-through), and registered with a reset-to-zero output
// register otherwise.
module fifo_mem #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [PTR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [PTR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the incoming word at the write address.
    // NOTE: the storage array has no reset; occupancy logic decides which
    // entries are meaningful, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

`ifdef FIFO_FWFT_EN
    // Read port shows the addressed word immediately; no read strobe needed.
    assign rdata_o = mem[raddr_i];

    logic unused_fwft;
    assign unused_fwft = rst_i ^ re_i;
`else
    // Read port loads the addressed word on an accepted read and holds it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, registered occupancy
// count and flags, programmable almost-full/almost-empty thresholds, and
// wrap-toggle full/empty detection so all DEPTH entries are usable.
// Compile-time option: define FIFO_FWFT_EN for first-word-fall-through reads
// (rdata_o shows the head word with zero latency, rd_valid_o = !empty_o);
// otherwise rdata_o is registered with one cycle of read latency.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 wr_en_i,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 wr_error_o,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 rd_valid_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic                 rd_error_o,
    output logic [PTR_WIDTH:0]   count_o
);

    localparam int                   CW       = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH:0]   AF_CNT   = CW'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0]   AE_CNT   = CW'(AE_LEVEL);

    if (!ptr_width_legal(DEPTH, PTR_WIDTH)) begin : g_bad_ptr_width
        $error("sync_fifo_param: PTR_WIDTH must equal clog2(DEPTH) and DEPTH must be >= 2");
    end
    if (!levels_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("sync_fifo_param: AF_LEVEL/AE_LEVEL out of range or AE_LEVEL >= AF_LEVEL");
    end

    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                 wr_tgl, rd_tgl;
    logic [PTR_WIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic                 wr_tgl_nxt, rd_tgl_nxt;
    logic [PTR_WIDTH:0]   count_nxt;
    logic                 wr_accept, rd_accept;
    logic [WIDTH-1:0]     mem_rdata;

    // Acceptance uses the registered flags as they stand at the start of the
    // cycle; a full FIFO can still take a read and an empty one a write.
    assign wr_accept = wr_en_i && !full_o;
    assign rd_accept = rd_en_i && !empty_o;

    // Next pointer/toggle/count: wrap explicitly at DEPTH-1 and flip the toggle.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        wr_tgl_nxt = wr_tgl;
        rd_ptr_nxt = rd_ptr;
        rd_tgl_nxt = rd_tgl;
        count_nxt  = count_o;
        if (wr_accept) begin
            if (wr_ptr == LAST_PTR) begin
                wr_ptr_nxt = '0;
                wr_tgl_nxt = ~wr_tgl;
            end else begin
                wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
            end
        end
        if (rd_accept) begin
            if (rd_ptr == LAST_PTR) begin
                rd_ptr_nxt = '0;
                rd_tgl_nxt = ~rd_tgl;
            end else begin
                rd_ptr_nxt = rd_ptr + PTR_WIDTH'(1);
            end
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count_o + CW'(1);
            2'b01:   count_nxt = count_o - CW'(1);
            default: count_nxt = count_o;
        endcase
    end

    // Pointer, count, flag and error registers; flags are computed from the
    // next-state values so they line up with count_o on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_tgl         <= 1'b0;
            rd_tgl         <= 1'b0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= (AF_LEVEL == 0);
            almost_empty_o <= 1'b1;
            wr_error_o     <= 1'b0;
            rd_error_o     <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_tgl         <= wr_tgl_nxt;
            rd_tgl         <= rd_tgl_nxt;
            count_o        <= count_nxt;
            full_o         <= (wr_ptr_nxt == rd_ptr_nxt) && (wr_tgl_nxt != rd_tgl_nxt);
            empty_o        <= (wr_ptr_nxt == rd_ptr_nxt) && (wr_tgl_nxt == rd_tgl_nxt);
            almost_full_o  <= (count_nxt >= AF_CNT);
            almost_empty_o <= (count_nxt <= AE_CNT);
            wr_error_o     <= wr_en_i && full_o;
            rd_error_o     <= rd_en_i && empty_o;
        end
    end

    fifo_mem #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr),
        .wdata_i (wdata_i),
        .re_i    (rd_accept),
        .raddr_i (rd_ptr),
        .rdata_o (mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    // Head word is visible whenever the FIFO holds data; zero while empty.
    assign rdata_o    = empty_o ? '0 : mem_rdata;
    assign rd_valid_o = !empty_o;
`else
    assign rdata_o = mem_rdata;

    // Valid pulses for the one cycle after an accepted read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_accept;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=5, AF=4, AE=1). A reference
// occupancy model predicts flags and errors; written words are queued and
// compared when the DUT presents them. Works in both read modes
// (FIFO_FWFT_EN defined or not).
module tb_sync_fifo_param;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int PW    = 3;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             rd_en;
    logic             full, almost_full, wr_error;
    logic [WIDTH-1:0] rdata;
    logic             rd_valid, empty, almost_empty, rd_error;
    logic [PW:0]      count;

    int               tests_run;
    int               tests_failed;
    int               mdl_count;
    logic [WIDTH-1:0] exp_q [$];

    sync_fifo_param #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wdata_i        (wdata),
        .wr_en_i        (wr_en),
        .full_o         (full),
        .almost_full_o  (almost_full),
        .wr_error_o     (wr_error),
        .rd_en_i        (rd_en),
        .rdata_o        (rdata),
        .rd_valid_o     (rd_valid),
        .empty_o        (empty),
        .almost_empty_o (almost_empty),
        .rd_error_o     (rd_error),
        .count_o        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare registered status against the occupancy model.
    task automatic check_status(input bit exp_wr_err, input bit exp_rd_err);
        check("count", 32'(count), 32'(mdl_count));
        check("full", 32'(full), 32'(mdl_count == DEPTH));
        check("empty", 32'(empty), 32'(mdl_count == 0));
        check("almost_full", 32'(almost_full), 32'(mdl_count >= AF));
        check("almost_empty", 32'(almost_empty), 32'(mdl_count <= AE));
        check("wr_error", 32'(wr_error), 32'(exp_wr_err));
        check("rd_error", 32'(rd_error), 32'(exp_rd_err));
    endtask

    // One clock cycle of stimulus; called #1 after a rising edge.
    task automatic cycle(input bit wr, input logic [WIDTH-1:0] wd, input bit rd);
        int pre;
        bit wacc, racc, werr, rerr;
        logic [WIDTH-1:0] head;
        pre   = mdl_count;
        wacc  = wr && (pre < DEPTH);
        racc  = rd && (pre > 0);
        werr  = wr && (pre == DEPTH);
        rerr  = rd && (pre == 0);
        wr_en = wr;
        wdata = wd;
        rd_en = rd;
`ifdef FIFO_FWFT_EN
        check("fwft_valid", 32'(rd_valid), 32'(pre > 0));
        if (racc) begin
            head = exp_q.pop_front();
            check("fwft_rdata", 32'(rdata), 32'(head));
        end
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
        check("rd_valid", 32'(rd_valid), 32'(racc));
        if (racc) begin
            head = exp_q.pop_front();
            check("rdata", 32'(rdata), 32'(head));
        end
`endif
        if (wacc) exp_q.push_back(wd);
        mdl_count = pre + int'(wacc) - int'(racc);
        check_status(werr, rerr);
    endtask

    // Reset for one cycle with requests asserted; they must be ignored.
    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hEE;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mdl_count = 0;
        exp_q.delete();
        check_status(1'b0, 1'b0);
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_rdata", 32'(rdata), 32'(0));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mdl_count    = 0;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fill 0x11..0x55, then a write while full.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0);
        cycle(1'b1, 8'h66, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous request while full: read wins, write errors.
        cycle(1'b1, 8'h77, 1'b1);

        // Drain the rest, then a read while empty.
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous request while empty: write wins, read errors.
        cycle(1'b1, 8'hA5, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Write 3 / read 3 twice so both pointers cross index 4 -> 0.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + r * 4 + i), 1'b0);
            for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0);

        // Steady stream at count 2.
        cycle(1'b1, 8'hC0, 1'b0);
        cycle(1'b1, 8'hC1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        // Reset mid-operation at count 3, then a read must error.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
        do_reset();
        cycle(1'b0, 8'h00, 1'b1);

        // Post-reset data path still works.
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
